decim_fir_sequencer: RTL and testbench
======================================

# decim_fir_sequencer

Scheduler for the final decimation FIR stage of the PDM microphone chain. It accepts CIC-stage output samples into a circular history buffer and, on every DECIM-th sample, runs one time-multiplexed MAC pass over NTAPS taps. The single multiplier is fed from an external synchronous coefficient ROM. It emits one rounded, saturated Q1.15 `audio_sample` with a single-cycle `audio_valid`, which feeds the top-level audio/SPI path.

## Interface
- `NTAPS`, default 32: number of FIR taps; power of two, ≥ 4.
- `DECIM`, default 6: decimation factor (96 kHz in → 16 kHz out).
- `DEPTH`, default 64: history buffer entries; power of two, must satisfy ≥ NTAPS + DECIM.
- `ACCW`, default 40: accumulator width.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_sample` in 16: signed Q1.15 CIC output.
- `in_valid` in 1: one-cycle strobe; `in_sample` is valid when high.
- `coef_addr` out log2(NTAPS): tap index to the coefficient ROM.
- `coef_data` in 16: signed Q1.15 coefficient; valid one cycle after `coef_addr` (synchronous ROM).
- `audio_sample` out 16: signed Q1.15 filtered output.
- `audio_valid` out 1: one-cycle strobe marking a new `audio_sample`.
- `busy` out 1: high while a MAC pass is in progress.
- `overrun` out 1: sticky flag; cleared only by reset.

## Operation
- **Reset.** `audio_sample`=0, `audio_valid`=0, `busy`=0, `overrun`=0, `coef_addr`=0. Write pointer `wp`=0, decimation counter `dcnt`=0, accumulator=0, all buffer entries=0, state=IDLE.
- **Sample intake.** Every `in_valid` writes `in_sample` to `buf[wp]` and increments `wp` mod DEPTH. Intake happens in every state.
- **Decimation counter.** `dcnt` increments on each `in_valid` and wraps at DECIM-1. The `in_valid` that arrives with `dcnt`==DECIM-1 is the trigger.
- **Trigger handling.**
  - Trigger with state IDLE: `base` ← address just written, `k` ← 0, accumulator ← 0, state → ISSUE.
  - Trigger in any other state: sample is still stored, `dcnt` still wraps, no pass starts, `overrun` ← 1. No output is produced for that trigger.
- **State machine.**
  - IDLE: wait for a trigger.
  - ISSUE (NTAPS cycles): `coef_addr`=`k`; register `sample_q` ← `buf[(base−k) mod DEPTH]`, aligned with the ROM latency; `k`++. Go to DRAIN after `k`=NTAPS−1.
  - DRAIN (1 cycle): final accumulate.
  - ROUND (1 cycle): round and saturate.
  - After ROUND: return to IDLE; register `audio_sample` and pulse `audio_valid`.
- **MAC.** acc += `sample_q` × `coef_data` (signed 16×16 → 32-bit, sign-extended to ACCW). The accumulate enable is the issue-valid delayed two edges, so tap k pairs newest-minus-k with coef[k].
- **Rounding and saturation.** result = (acc + 2^14) >>> 15, arithmetic shift. Clamp to [−32768, 32767].
- **Buffer safety.** Writes during a pass land outside the active window because DEPTH ≥ NTAPS + DECIM. Window reads use the snapshotted `base`.
- **Busy.** `busy`=1 in ISSUE, DRAIN and ROUND; 0 in IDLE.

## Timing
- **Latency.** Let E0 be the edge that samples the trigger.
  - ISSUE covers cycles E0–E(NTAPS).
  - Accumulates occur at edges E2…E(NTAPS+1).
  - At E(NTAPS+2): `audio_sample` updates, `audio_valid`=1 for exactly one cycle, state=IDLE, `busy`=0.
  - NTAPS=32 gives 34 edges.
- **Trigger on the return edge.** A trigger sampled at E(NTAPS+2), i.e. still in ROUND, counts as busy and sets `overrun`. A trigger at E(NTAPS+3) or later starts normally.
- **Minimum spacing.** Overrun-free operation requires trigger spacing ≥ NTAPS+3 cycles. `in_valid` every 16 clk with DECIM=6 gives 96.
- **Output hold.** `audio_sample` holds its value between `audio_valid` pulses.
- **Reset mid-pass.** All outputs return to reset values immediately and the pass is abandoned. After release, the first pass needs DECIM new `in_valid` strobes.
- **Address wrap.** `(base−k)` wraps mod DEPTH, e.g. `base`=2, k=5 → entry DEPTH−3.

## Test plan
- **Impulse coefficients.** ROM coef[0]=32767, others 0. Ramp `in_sample` 1000, 1001, …, one `in_valid` per 16 clk. → Each `audio_valid` equals the trigger sample (1005, 1011, …); the first pulse comes 34 edges after the 6th strobe.
- **DC gain.** All coef=1024, DC input 16000 (after ≥ 32 samples). → `audio_sample`=16000 every output.
- **Saturation.** All coef=32767.
  - Input 32767 → 32767.
  - Input −32768 → −32768.
- **Tap ordering.** coef[k]=k. Input x[n] alternating 0/256, starting at 0 after reset. → Output matches the bench's reference dot product with newest-first ordering, bit-exact including wrap across entry 0.
- **Overrun.** `in_valid` every clk, DECIM=6. → `overrun`=1 after the 2nd trigger; `audio_valid` pulses only for accepted triggers, spaced ≥ 36 edges; data remains correct.
- **Reset mid-pass.** Drop `reset_n` during ISSUE (k=10). → `busy`/`audio_valid`/`overrun`/`audio_sample`=0 at once; after release, no `audio_valid` until 6 new strobes plus 34 edges.

Source files
------------

// File: rtl/decim_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decim_fir_sequencer
// Brief    : Decimating FIR scheduler: circular sample history, one
//            time-multiplexed MAC pass per DECIM inputs, Q1.15 round/saturate.
// Revision : 1.0
// ============================================================================
module decim_fir_sequencer #(
    parameter int NTAPS = 32,
    parameter int DECIM = 6,
    parameter int DEPTH = 64,
    parameter int ACCW  = 40
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [15:0]              in_sample,
    input  logic                     in_valid,
    output logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [15:0]              coef_data,
    output logic [15:0]              audio_sample,
    output logic                     audio_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int KW = $clog2(NTAPS);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_round = 2'd3;

    localparam logic [DW-1:0]          c_dcnt_last  = DW'(DECIM - 1);
    localparam logic [KW-1:0]          c_k_last     = KW'(NTAPS - 1);
    localparam logic signed [ACCW-1:0] c_round_bias = ACCW'(16384);
    localparam logic signed [ACCW-1:0] c_sat_max    = ACCW'(32767);
    localparam logic signed [ACCW-1:0] c_sat_min    = ACCW'(-32768);

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [15:0]             r_buf [DEPTH];
    logic [AW-1:0]           r_wp;
    logic [AW-1:0]           r_base;
    logic [DW-1:0]           r_dcnt;
    logic [KW-1:0]           r_k;
    logic signed [15:0]      r_sample_q;
    logic                    r_acc_en;
    logic signed [ACCW-1:0]  r_acc;
    logic [15:0]             r_audio_sample;
    logic                    r_audio_valid;
    logic                    r_overrun;

    logic                    w_trigger;
    logic                    w_start;
    logic [AW-1:0]           w_rd_addr;
    logic signed [31:0]      w_prod;
    logic signed [ACCW-1:0]  w_rounded;
    logic [15:0]             w_sat;

    assign w_trigger = in_valid && (r_dcnt == c_dcnt_last);
    assign w_start   = w_trigger && (r_state == c_idle);
    assign w_rd_addr = r_base - {{(AW-KW){1'b0}}, r_k};
    assign w_prod    = r_sample_q * $signed(coef_data);
    assign w_rounded = (r_acc + c_round_bias) >>> 15;

    always_comb begin
        w_sat = w_rounded[15:0];
        if (w_rounded > c_sat_max) begin
            w_sat = 16'h7fff;
        end else if (w_rounded < c_sat_min) begin
            w_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (w_start) w_state_next = c_issue;
            c_issue: if (r_k == c_k_last) w_state_next = c_drain;
            c_drain: w_state_next = c_round;
            c_round: w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    // Intake runs in every state; the pass only ever reads behind the snapshotted base.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_wp   <= '0;
            r_dcnt <= '0;
        end else if (in_valid) begin
            r_buf[r_wp] <= in_sample;
            r_wp        <= r_wp + 1'b1;
            r_dcnt      <= (r_dcnt == c_dcnt_last) ? '0 : r_dcnt + 1'b1;
        end
    end

    // Sample fetch and ROM read both land one edge after issue, so the MAC
    // enable is the issue state seen through one more register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base         <= '0;
            r_k            <= '0;
            r_sample_q     <= '0;
            r_acc_en       <= 1'b0;
            r_acc          <= '0;
            r_audio_sample <= '0;
            r_audio_valid  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_acc_en      <= (r_state == c_issue);
            r_audio_valid <= (r_state == c_round);
            if (w_start) begin
                r_base <= r_wp;
                r_k    <= '0;
                r_acc  <= '0;
            end else begin
                if (r_state == c_issue) r_k <= r_k + 1'b1;
                if (r_acc_en) r_acc <= r_acc + ACCW'(w_prod);
            end
            if (r_state == c_issue) r_sample_q <= r_buf[w_rd_addr];
            if (r_state == c_round) r_audio_sample <= w_sat;
            if (w_trigger && (r_state != c_idle)) r_overrun <= 1'b1;
        end
    end

    assign coef_addr    = r_k;
    assign audio_sample = r_audio_sample;
    assign audio_valid  = r_audio_valid;
    assign busy         = (r_state != c_idle);
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_decim_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decim_fir_sequencer
// Brief    : Directed self-checking bench for decim_fir_sequencer with a
//            synchronous coefficient ROM and newest-first reference FIR.
// Revision : 1.0
// ============================================================================
module tb_decim_fir_sequencer;

    localparam int NTAPS = 32;
    localparam int DECIM = 6;
    localparam int DEPTH = 64;
    localparam int ACCW  = 40;
    localparam int LAT   = NTAPS + 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic signed [15:0] in_sample = '0;
    logic               in_valid = 1'b0;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic signed [15:0] audio_sample;
    logic               audio_valid;
    logic               busy;
    logic               overrun;

    logic signed [15:0] rom [NTAPS];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hist[$];
    int m_dcnt = 0;
    int last_acc = -1000;
    int acc_n[$];
    int acc_edge[$];
    int obs_val[$];
    int obs_edge[$];

    decim_fir_sequencer #(
        .NTAPS(NTAPS), .DECIM(DECIM), .DEPTH(DEPTH), .ACCW(ACCW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .audio_sample (audio_sample),
        .audio_valid  (audio_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) coef_data <= rom[coef_addr];

    always @(negedge clk) begin
        if (reset_n && audio_valid) begin
            obs_val.push_back(int'(audio_sample));
            obs_edge.push_back(cyc);
        end
    end

    function automatic int ref_out(input int n);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NTAPS; k++)
            if (n - k >= 0) acc += longint'(hist[n-k]) * longint'(rom[k]);
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic model_clear();
        hist.delete();
        acc_n.delete();
        acc_edge.delete();
        obs_val.delete();
        obs_edge.delete();
        m_dcnt   = 0;
        last_acc = -1000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Drives one strobe on the next edge; the trigger edge is cyc+1 at this negedge.
    task automatic push(input int s);
        @(negedge clk);
        in_sample = 16'(s);
        in_valid  = 1'b1;
        hist.push_back(s);
        if (m_dcnt == DECIM - 1) begin
            if (cyc + 1 >= last_acc + NTAPS + 3) begin
                last_acc = cyc + 1;
                acc_n.push_back(hist.size() - 1);
                acc_edge.push_back(cyc + 1);
            end
            m_dcnt = 0;
        end else begin
            m_dcnt++;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic rom_weighted();
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'(((k % 2) ? -1 : 1) * (k + 1) * 60);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NTAPS; k++) rom[k] = '0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        checks++; if (audio_sample !== 16'sd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", audio_sample); end
        checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", audio_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (coef_addr !== 5'd0) begin errors++; $display("FAIL reset_coef_addr: got %0d expected 0", coef_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_impulse();
        int exp_v[3] = '{1005, 1011, 1017};
        for (int k = 0; k < NTAPS; k++) rom[k] = (k == 0) ? 16'sd32767 : 16'sd0;
        do_reset();
        for (int i = 0; i < 18; i++) begin push(1000 + i); idle(15); end
        idle(40);
        checks++; if (obs_val.size() !== 3) begin errors++; $display("FAIL impulse_count: got %0d expected 3", obs_val.size()); end
        for (int i = 0; i < obs_val.size() && i < 3; i++) begin
            checks++; if (obs_val[i] !== exp_v[i]) begin errors++; $display("FAIL impulse_val[%0d]: got %0d expected %0d", i, obs_val[i], exp_v[i]); end
            checks++; if (obs_edge[i] - acc_edge[i] !== LAT) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", i, obs_edge[i] - acc_edge[i], LAT); end
        end
        checks++; if (audio_sample !== 16'sd1017) begin errors++; $display("FAIL impulse_hold: got %0d expected 1017", audio_sample); end
    endtask

    task automatic test_dc_gain();
        int n;
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'sd1024;
        do_reset();
        for (int i = 0; i < 48; i++) begin push(16000); idle(15); end
        idle(40);
        checks++; if (obs_val.size() !== 8) begin errors++; $display("FAIL dc_count: got %0d expected 8", obs_val.size()); end
        for (int i = 0; i < obs_val.size() && i < 8; i++) begin
            n = (6 * (i + 1) < 32) ? 6 * (i + 1) : 32;
            checks++; if (obs_val[i] !== n * 500) begin errors++; $display("FAIL dc_val[%0d]: got %0d expected %0d", i, obs_val[i], n * 500); end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'sd32767;
        do_reset();
        for (int i = 0; i < 36; i++) begin push(32767); idle(7); end
        idle(40);
        checks++; if (obs_val.size() !== 6) begin errors++; $display("FAIL sat_pos_count: got %0d expected 6", obs_val.size()); end
        for (int i = 0; i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== 32767) begin errors++; $display("FAIL sat_pos[%0d]: got %0d expected 32767", i, obs_val[i]); end
        end
        do_reset();
        for (int i = 0; i < 36; i++) begin push(-32768); idle(7); end
        idle(40);
        checks++; if (obs_val.size() !== 6) begin errors++; $display("FAIL sat_neg_count: got %0d expected 6", obs_val.size()); end
        for (int i = 0; i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== -32768) begin errors++; $display("FAIL sat_neg[%0d]: got %0d expected -32768", i, obs_val[i]); end
        end
    endtask

    task automatic test_tap_ordering();
        int e;
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'(k);
        do_reset();
        for (int i = 0; i < 80; i++) begin push((i % 2) ? 256 : 0); idle(7); end
        idle(40);
        checks++; if (obs_val.size() !== 13) begin errors++; $display("FAIL taps_alt_count: got %0d expected 13", obs_val.size()); end
        for (int i = 0; i < obs_val.size() && i < acc_n.size(); i++) begin
            e = ref_out(acc_n[i]);
            checks++; if (obs_val[i] !== e) begin errors++; $display("FAIL taps_alt[%0d]: got %0d expected %0d", i, obs_val[i], e); end
        end
        rom_weighted();
        do_reset();
        for (int i = 0; i < 80; i++) begin push(((i * 1237) % 20000) - 10000); idle(7); end
        idle(40);
        checks++; if (obs_val.size() !== 13) begin errors++; $display("FAIL taps_wt_count: got %0d expected 13", obs_val.size()); end
        for (int i = 0; i < obs_val.size() && i < acc_n.size(); i++) begin
            e = ref_out(acc_n[i]);
            checks++; if (obs_val[i] !== e) begin errors++; $display("FAIL taps_wt[%0d]: got %0d expected %0d", i, obs_val[i], e); end
        end
    endtask

    task automatic test_overrun();
        int e;
        rom_weighted();
        do_reset();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b expected 0", overrun); end
        for (int i = 0; i < 11; i++) push(i * 37 - 1500);
        idle(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_trigger: got %b expected 0", overrun); end
        push(11 * 37 - 1500);
        idle(1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_second_trigger: got %b expected 1", overrun); end
        for (int i = 12; i < 90; i++) push(i * 37 - 1500);
        idle(45);
        checks++; if (obs_val.size() !== 3) begin errors++; $display("FAIL ovr_count: got %0d expected 3", obs_val.size()); end
        for (int i = 0; i < obs_val.size() && i < acc_n.size(); i++) begin
            e = ref_out(acc_n[i]);
            checks++; if (obs_val[i] !== e) begin errors++; $display("FAIL ovr_val[%0d]: got %0d expected %0d", i, obs_val[i], e); end
            checks++; if (obs_edge[i] - acc_edge[i] !== LAT) begin errors++; $display("FAIL ovr_latency[%0d]: got %0d expected %0d", i, obs_edge[i] - acc_edge[i], LAT); end
            if (i > 0) begin
                checks++; if (obs_edge[i] - obs_edge[i-1] < NTAPS + 4) begin errors++; $display("FAIL ovr_spacing[%0d]: got %0d expected >= %0d", i, obs_edge[i] - obs_edge[i-1], NTAPS + 4); end
            end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_pass();
        int e;
        rom_weighted();
        do_reset();
        for (int i = 0; i < 6; i++) begin push(i * 5000 + 1000); idle(7); end
        idle(40);
        checks++; if (obs_val.size() !== 1) begin errors++; $display("FAIL rmp_pre_count: got %0d expected 1", obs_val.size()); end
        if (obs_val.size() > 0) begin
            e = ref_out(acc_n[0]);
            checks++; if (obs_val[0] !== e) begin errors++; $display("FAIL rmp_pre_val: got %0d expected %0d", obs_val[0], e); end
        end
        for (int i = 0; i < 12; i++) push(i * 700 - 4000);
        idle(1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rmp_overrun_set: got %b expected 1", overrun); end
        repeat (4) @(negedge clk);
        checks++; if (coef_addr !== 5'd10) begin errors++; $display("FAIL rmp_k: got %0d expected 10", coef_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmp_busy_pre: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmp_busy: got %b expected 0", busy); end
        checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL rmp_valid: got %b expected 0", audio_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmp_overrun: got %b expected 0", overrun); end
        checks++; if (audio_sample !== 16'sd0) begin errors++; $display("FAIL rmp_sample: got %0d expected 0", audio_sample); end
        checks++; if (coef_addr !== 5'd0) begin errors++; $display("FAIL rmp_coef_addr: got %0d expected 0", coef_addr); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        for (int i = 0; i < 5; i++) begin push(i * 3000 - 7000); idle(7); end
        idle(50);
        checks++; if (obs_val.size() !== 0) begin errors++; $display("FAIL rmp_early_output: got %0d expected 0", obs_val.size()); end
        push(5 * 3000 - 7000);
        idle(40);
        checks++; if (obs_val.size() !== 1) begin errors++; $display("FAIL rmp_post_count: got %0d expected 1", obs_val.size()); end
        if (obs_val.size() > 0 && acc_n.size() > 0) begin
            e = ref_out(acc_n[0]);
            checks++; if (obs_val[0] !== e) begin errors++; $display("FAIL rmp_post_val: got %0d expected %0d", obs_val[0], e); end
            checks++; if (obs_edge[0] - acc_edge[0] !== LAT) begin errors++; $display("FAIL rmp_post_latency: got %0d expected %0d", obs_edge[0] - acc_edge[0], LAT); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_gain();
        test_saturation();
        test_tap_ordering();
        test_overrun();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
